// File: rtl/shifter_ctl.sv
`default_nettype none
// ============================================================================
// Module   : shifter_ctl
// Brief    : Builds the channel-compaction shift table from a mask, drains the
//            shifter before reconfiguring it and gates the stream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shifter_ctl #(
    parameter int DW = 32,
    parameter int DL = $clog2(DW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     cfg_mask,
    input  logic              cfg_load,
    input  logic              ctl_run,
    output logic              sts_busy,
    output logic [DL:0]       sts_width,
    output logic              shf_ena,
    output logic              shf_clr,
    output logic [DW*DL-1:0]  shf_shift,
    input  logic              up_valid,
    output logic              up_ready,
    output logic              dn_valid,
    input  logic              dn_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CALC  = 2'd2,
        S_READY = 2'd3
    } state_t;

    localparam logic [DL-1:0] c_drain_last = DL'(DL - 1);
    localparam logic [DL-1:0] c_calc_last  = DL'(DW - 1);
    localparam logic [DL:0]   c_width_full = (DL+1)'(DW);

    state_t              r_state;
    logic [DW-1:0]       r_mask;
    logic [DL-1:0]       r_cnt;
    logic [DL:0]         r_zcnt;
    logic [DW*DL-1:0]    r_work;

    logic                w_bit;
    logic [DL-1:0]       w_entry;
    logic [DL:0]         w_zcnt_next;
    logic [DW*DL-1:0]    w_work;

    // One table entry per CALC cycle; the zero count so far is its shift.
    always_comb begin
        w_bit       = r_mask[r_cnt];
        w_entry     = w_bit ? r_zcnt[DL-1:0] : '0;
        w_zcnt_next = r_zcnt + {{DL{1'b0}}, ~w_bit};
        w_work      = r_work;
        for (int b = 0; b < DW; b++) begin
            if (DL'(b) == r_cnt) begin
                w_work[b*DL +: DL] = w_entry;
            end
        end
    end

    always_comb begin
        sts_busy = (r_state == S_DRAIN) || (r_state == S_CALC);
        shf_ena  = (r_state == S_DRAIN) || ((r_state == S_READY) && ctl_run);
        shf_clr  = (r_state == S_CALC) && (r_cnt == '0);
        up_ready = (r_state == S_READY) && dn_ready && ctl_run;
        dn_valid = (r_state == S_READY) && up_valid && ctl_run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_zcnt    <= '0;
            r_work    <= '0;
            shf_shift <= '0;
            sts_width <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_mask  <= cfg_mask;
                        r_cnt   <= '0;
                        r_zcnt  <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_DRAIN: begin
                    if (cfg_load) begin
                        r_mask <= cfg_mask;
                    end
                    if (r_cnt == c_drain_last) begin
                        r_cnt   <= '0;
                        r_zcnt  <= '0;
                        r_state <= S_CALC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CALC: begin
                    if (cfg_load) begin
                        r_mask <= cfg_mask;
                        r_cnt  <= '0;
                        r_zcnt <= '0;
                    end else begin
                        r_work <= w_work;
                        r_zcnt <= w_zcnt_next;
                        if (r_cnt == c_calc_last) begin
                            // Table and width publish together as busy falls.
                            shf_shift <= w_work;
                            sts_width <= c_width_full - w_zcnt_next;
                            r_cnt     <= '0;
                            r_state   <= S_READY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (cfg_load) begin
                        r_mask  <= cfg_mask;
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shifter_ctl.sv
`default_nettype none
// Testbench for shifter_ctl (DW=8): scoreboard of expected tables per
// reconfiguration, plus directed checks of drain, reset and run gating.
module tb_shifter_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_mask;
    logic        cfg_load;
    logic        ctl_run;
    logic        sts_busy;
    logic [3:0]  sts_width;
    logic        shf_ena;
    logic        shf_clr;
    logic [23:0] shf_shift;
    logic        up_valid;
    logic        up_ready;
    logic        dn_valid;
    logic        dn_ready;

    shifter_ctl #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mask  (cfg_mask),
        .cfg_load  (cfg_load),
        .ctl_run   (ctl_run),
        .sts_busy  (sts_busy),
        .sts_width (sts_width),
        .shf_ena   (shf_ena),
        .shf_clr   (shf_clr),
        .shf_shift (shf_shift),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] tbl;
        logic [3:0]  width;
        int          blen;
        int          nclr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Hand-computed tables, entry 7 first.
    localparam logic [23:0] T_A6 = {3'd4, 3'd0, 3'd3, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
    localparam logic [23:0] T_81 = {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [23:0] T_Z  = 24'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] t, input logic [3:0] w, input int bl, input int nc);
        exp_t e;
        e.tbl = t; e.width = w; e.blen = bl; e.nclr = nc;
        q.push_back(e);
    endtask

    // Scoreboard monitor: measures each busy window and checks the result
    // published when it closes.
    int  busy_cnt = 0;
    int  clr_cnt  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            clr_cnt   = 0;
            prev_busy = 1'b0;
        end else begin
            if (sts_busy) begin
                busy_cnt++;
                if (shf_clr) clr_cnt++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_busy_end", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_table", 32'(shf_shift), 32'(e.tbl));
                    chk("sb_width", 32'(sts_width), 32'(e.width));
                    chk("sb_busy_len", 32'(busy_cnt), 32'(e.blen));
                    chk("sb_clr_pulses", 32'(clr_cnt), 32'(e.nclr));
                end
                busy_cnt = 0;
                clr_cnt  = 0;
            end
            prev_busy = sts_busy;
        end
    end

    task automatic load(input logic [7:0] m);
        @(posedge clk); #1;
        cfg_load = 1'b1;
        cfg_mask = m;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        cfg_mask = 8'h5A;   // later changes must be ignored
    endtask

    task automatic wait_idle;
        logic done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!sts_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("busy_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cfg_mask = 8'h00; cfg_load = 1'b0;
        ctl_run = 1'b1; up_valid = 1'b1; dn_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(sts_busy), 32'd0);
        chk("rst_width", 32'(sts_width), 32'd0);
        chk("rst_table", 32'(shf_shift), 32'd0);
        chk("rst_ena", 32'(shf_ena), 32'd0);
        chk("rst_clr", 32'(shf_clr), 32'd0);
        chk("rst_up_ready", 32'(up_ready), 32'd0);
        chk("rst_dn_valid", 32'(dn_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_hold_busy", 32'(sts_busy), 32'd0);
        chk("idle_hold_up_ready", 32'(up_ready), 32'd0);
        chk("idle_hold_ena", 32'(shf_ena), 32'd0);

        // From IDLE: CALC only
        push(T_A6, 4'd4, 8, 1);
        load(8'hA6);
        wait_idle();

        // Run gating in READY is combinational
        chk("ready_ena", 32'(shf_ena), 32'd1);
        chk("ready_up_ready", 32'(up_ready), 32'd1);
        chk("ready_dn_valid", 32'(dn_valid), 32'd1);
        ctl_run = 1'b0; #1;
        chk("run0_ena", 32'(shf_ena), 32'd0);
        chk("run0_up_ready", 32'(up_ready), 32'd0);
        chk("run0_dn_valid", 32'(dn_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("run0_table_held", 32'(shf_shift), 32'(T_A6));
        ctl_run = 1'b1; #1;
        chk("run1_ena", 32'(shf_ena), 32'd1);
        chk("run1_up_ready", 32'(up_ready), 32'd1);
        up_valid = 1'b0; #1;
        chk("dn_valid_follows_up", 32'(dn_valid), 32'd0);
        up_valid = 1'b1;
        dn_ready = 1'b0; #1;
        chk("up_ready_follows_dn", 32'(up_ready), 32'd0);
        dn_ready = 1'b1;

        // From READY: drain DL=3 cycles, then CALC; old table held meanwhile
        push(T_Z, 4'd4, 11, 1);
        load(8'h0F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_ena", 32'(shf_ena), 32'd1);
            chk("drain_up_ready", 32'(up_ready), 32'd0);
            chk("drain_dn_valid", 32'(dn_valid), 32'd0);
            chk("drain_table_held", 32'(shf_shift), 32'(T_A6));
        end
        @(negedge clk);
        chk("calc_first_clr", 32'(shf_clr), 32'd1);
        chk("calc_ena", 32'(shf_ena), 32'd0);
        chk("calc_table_held", 32'(shf_shift), 32'(T_A6));
        chk("calc_width_held", 32'(sts_width), 32'd4);
        wait_idle();

        push(T_Z, 4'd8, 11, 1);
        load(8'hFF);
        wait_idle();
        push(T_Z, 4'd0, 11, 1);
        load(8'h00);
        wait_idle();
        chk("zero_mask_ready", 32'(up_ready), 32'd1);
        push(T_81, 4'd2, 11, 1);
        load(8'h81);
        wait_idle();

        // Reset in the middle of CALC discards everything
        load(8'hA6);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midcalc_rst_busy", 32'(sts_busy), 32'd0);
        chk("midcalc_rst_table", 32'(shf_shift), 32'd0);
        chk("midcalc_rst_width", 32'(sts_width), 32'd0);
        chk("midcalc_rst_up_ready", 32'(up_ready), 32'd0);

        // Reload during CALC cycle 4 restarts the calculation
        push(T_81, 4'd2, 12, 2);
        load(8'hA6);
        repeat (3) @(posedge clk);
        #1;
        cfg_load = 1'b1;
        cfg_mask = 8'h81;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        cfg_mask = 8'hFF;
        wait_idle();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
